decode_issue_ctrl: RTL and testbench

- Controls the fetch-to-decode handoff in the 5-stage RISC-V pipeline.
- Holds fetched instructions in a 2-entry skid buffer (main + skid) so if_ready is registered. There is no combinational path from id_ready to if_ready.
- Detects load-use hazards against the EX stage and inserts bubbles.
- Squashes all held instructions on a branch/jump redirect.
- Feeds the decoder/immediate extender with id_instr/id_pc.

---
 rtl/decode_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_decode_issue_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl.sv
// rtl/decode_issue_ctrl.sv - fetch-to-decode skid buffer with load-use bubbles and redirect flush.
// Optional DECODE_PERF_EN adds stall/flush performance counters.
module decode_issue_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             if_ready,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [XLEN-1:0]  id_pc,
  input  logic             id_ready,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             redirect,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic            main_valid_q, main_valid_d;
  logic [31:0]     main_instr_q, main_instr_d;
  logic [XLEN-1:0] main_pc_q, main_pc_d;
  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            if_ready_q;

  logic       use_rs1, use_rs2, hazard, accept, issue;
  logic [6:0] opcode;
  logic [4:0] rs1, rs2;

  assign opcode = main_instr_q[6:0];
  assign rs1    = main_instr_q[19:15];
  assign rs2    = main_instr_q[24:20];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
      // Immediate CSR forms carry a zimm in the rs1 field, not a register.
      7'b1110011: use_rs1 = ~main_instr_q[14];
      default: ;
    endcase
  end

  assign hazard = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                  ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));

  assign if_ready = if_ready_q;
  assign id_valid = main_valid_q & ~hazard & ~redirect;
  assign id_instr = main_instr_q;
  assign id_pc    = main_pc_q;
  assign accept   = if_valid & if_ready_q;
  assign issue    = id_valid & id_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (redirect) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_valid_d = 1'b1;
        main_instr_d = if_instr;
        main_pc_d    = if_pc;
      end
    end else if (!skid_valid_q) begin
      if (issue && accept) begin
        main_instr_d = if_instr;
        main_pc_d    = if_pc;
      end else if (issue) begin
        main_valid_d = 1'b0;
      end else if (accept) begin
        skid_valid_d = 1'b1;
        skid_instr_d = if_instr;
        skid_pc_d    = if_pc;
      end
    end else if (issue) begin
      main_instr_d = skid_instr_q;
      main_pc_d    = skid_pc_q;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_instr_q <= 32'h0;
      main_pc_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0;
      skid_pc_q    <= '0;
      if_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      if_ready_q   <= ~(main_valid_d & skid_valid_d);
    end
  end

`ifdef DECODE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (main_valid_q & hazard & ~redirect) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// tb/tb_decode_issue_ctrl.sv - directed self-checking bench for decode_issue_ctrl.
module tb_decode_issue_ctrl;

`ifdef DECODE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, if_valid, if_ready, id_valid, id_ready;
  logic        ex_valid, ex_is_load, redirect;
  logic [31:0] if_instr, id_instr;
  logic [63:0] if_pc, id_pc;
  logic [4:0]  ex_rd;
  logic [31:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_issue_ctrl #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .redirect(redirect), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] ins, input logic [63:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
  endtask

  function automatic logic [31:0] perf(input int n);
    return PERF ? n : 0;
  endfunction

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 64'h0;
    id_ready = 1'b0; ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; redirect = 1'b0;
    tick(); tick();
    reset = 1'b0; #1;
    check_eq("rst_if_ready", if_ready, 1);
    check_eq("rst_id_valid", id_valid, 0);
    check_eq("rst_id_instr", id_instr, 0);
    check_eq("rst_id_pc", id_pc, 0);
    check_eq("rst_stall", stall_cycles, 0);
    check_eq("rst_flush", flush_count, 0);

    // Simple issue
    offer(32'h00100093, 64'h80000000); id_ready = 1'b1;
    tick(); if_valid = 1'b0; #1;
    check_eq("t1_valid", id_valid, 1);
    check_eq("t1_instr", id_instr, 32'h00100093);
    check_eq("t1_pc", id_pc, 64'h80000000);
    tick();
    check_eq("t1_empty", id_valid, 0);

    // Load-use bubble on rs1
    offer(32'h00208133, 64'h10); id_ready = 1'b0;
    tick(); if_valid = 1'b0;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1; id_ready = 1'b1; #1;
    check_eq("t2_bubble", id_valid, 0);
    tick(); ex_valid = 1'b0; #1;
    check_eq("t2_stall_cnt", stall_cycles, perf(1));
    check_eq("t2_issue", id_valid, 1);
    check_eq("t2_instr", id_instr, 32'h00208133);
    tick();
    // ex_rd = x0 never hazards
    offer(32'h00208133, 64'h14); id_ready = 1'b0;
    tick(); if_valid = 1'b0;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; #1;
    check_eq("t2_rd0", id_valid, 1);
    id_ready = 1'b1; ex_valid = 1'b0; tick();
    // LUI whose rs1 field happens to equal ex_rd
    offer(32'h000080b7, 64'h18); id_ready = 1'b0;
    tick(); if_valid = 1'b0;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1; #1;
    check_eq("t2_lui", id_valid, 1);
    id_ready = 1'b1; tick(); ex_valid = 1'b0; #1;
    check_eq("t2_lui_gone", id_valid, 0);
    check_eq("t2_stall_keep", stall_cycles, perf(1));

    // Backpressure: two accepts fill the buffer
    id_ready = 1'b0;
    offer(32'h00100093, 64'h100); #1;
    check_eq("t3_rdy0", if_ready, 1);
    tick(); offer(32'h00200113, 64'h104); #1;
    check_eq("t3_rdy1", if_ready, 1);
    tick(); offer(32'h00300193, 64'h108); #1;
    check_eq("t3_full", if_ready, 0);
    tick();
    check_eq("t3_hold", id_instr, 32'h00100093);
    check_eq("t3_full2", if_ready, 0);
    id_ready = 1'b1; #1;
    check_eq("t3_i1", id_instr, 32'h00100093);
    check_eq("t3_i1v", id_valid, 1);
    tick();
    check_eq("t3_i2", id_instr, 32'h00200113);
    check_eq("t3_i2pc", id_pc, 64'h104);
    check_eq("t3_rdy_again", if_ready, 1);
    tick(); if_valid = 1'b0; #1;
    check_eq("t3_i3", id_instr, 32'h00300193);
    check_eq("t3_i3v", id_valid, 1);
    tick();
    check_eq("t3_empty", id_valid, 0);

    // Redirect while full
    id_ready = 1'b0;
    offer(32'h00400213, 64'h200); tick();
    offer(32'h00500293, 64'h204); tick();
    offer(32'h00600313, 64'h208); redirect = 1'b1; id_ready = 1'b1; #1;
    check_eq("t4_redir_v", id_valid, 0);
    tick(); redirect = 1'b0; if_valid = 1'b0; #1;
    check_eq("t4_empty", id_valid, 0);
    check_eq("t4_ready", if_ready, 1);
    check_eq("t4_flush", flush_count, perf(1));
    tick();
    check_eq("t4_none", id_valid, 0);
    // Redirect discards an accept from EMPTY
    offer(32'h00700393, 64'h20c); redirect = 1'b1; #1;
    check_eq("t4_acc_rdy", if_ready, 1);
    tick(); redirect = 1'b0; if_valid = 1'b0; #1;
    check_eq("t4_discard", id_valid, 0);
    check_eq("t4_flush2", flush_count, perf(2));

    // Reset mid-stall while full
    id_ready = 1'b0;
    offer(32'h00208133, 64'h300); tick();
    offer(32'h00100093, 64'h304); tick();
    if_valid = 1'b0; ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd1; id_ready = 1'b1; #1;
    check_eq("t5_bubble", id_valid, 0);
    tick();
    check_eq("t5_stall_cnt", stall_cycles, perf(2));
    check_eq("t5_full", if_ready, 0);
    reset = 1'b1; tick(); reset = 1'b0; ex_valid = 1'b0; #1;
    check_eq("t5_valid", id_valid, 0);
    check_eq("t5_ready", if_ready, 1);
    check_eq("t5_stall0", stall_cycles, 0);
    check_eq("t5_flush0", flush_count, 0);
    check_eq("t5_instr0", id_instr, 0);

    // CSR immediate form does not read rs1; register form does
    id_ready = 1'b0;
    offer(32'h34015073, 64'h400); tick(); if_valid = 1'b0;
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd2; #1;
    check_eq("t6_csrrwi", id_valid, 1);
    id_ready = 1'b1; ex_valid = 1'b0; tick();
    id_ready = 1'b0;
    offer(32'h34011073, 64'h404); tick(); if_valid = 1'b0;
    ex_valid = 1'b1; #1;
    check_eq("t6_csrrw", id_valid, 0);
    tick();
    check_eq("t6_stall", stall_cycles, perf(1));
    ex_valid = 1'b0; id_ready = 1'b1; #1;
    check_eq("t6_release", id_valid, 1);
    check_eq("t6_pc", id_pc, 64'h404);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
